// File: rtl/uart_pkg.sv
// Shared definitions for the parameterised UART transmitter.
// Contents: parity mode encodings, transmitter FSM state encodings and a
// helper that tells whether a parity mode emits a parity bit.
package uart_pkg;

    typedef enum logic [2:0] {
        ParNone  = 3'd0,
        ParEven  = 3'd1,
        ParOdd   = 3'd2,
        ParMark  = 3'd3,
        ParSpace = 3'd4
    } parity_e;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop1  = 3'd4,
        StStop2  = 3'd5,
        StBreak  = 3'd6
    } tx_state_e;

    // Encodings 0 and 5..7 send no parity bit.
    function automatic logic parity_on(logic [2:0] mode);
        return (mode == ParEven) || (mode == ParOdd) || (mode == ParMark) ||
               (mode == ParSpace);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO for the UART transmitter.
// Ports:
//   clk, reset_n    clock and synchronous active-low reset (empties the FIFO)
//   push, wdata     write strobe and data; ignored when full
//   pop             read strobe; ignored when empty
//   rdata           head word, valid whenever empty is low
//   level           registered count of stored words
//   full, empty     derived from level
module uart_tx_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic [LW-1:0]     level,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [LW-1:0]     level_q;
    logic              do_push;
    logic              do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign level   = level_q;
    assign rdata   = mem_q[rd_ptr_q];

    // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with transmit FIFO and break generation.
// Ports:
//   clk, reset_n            clock and synchronous active-low reset
//   baud_tick               one-clock enable, one per bit period
//   tx_data/tx_valid/tx_ready  write handshake into the FIFO
//   cfg_dbits/cfg_parity/cfg_stop2  frame format, sampled at frame start
//   break_req               request to hold the line low
//   txd                     registered serial output, idle high
//   busy                    FSM not idle
//   fifo_level              queued word count
//   tx_done                 one-clock pulse after the last stop bit of a frame
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               baud_tick,
    input  logic [DATA_W-1:0]                  tx_data,
    input  logic                               tx_valid,
    output logic                               tx_ready,
    input  logic [3:0]                         cfg_dbits,
    input  logic [2:0]                         cfg_parity,
    input  logic                               cfg_stop2,
    input  logic                               break_req,
    output logic                               txd,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic                               tx_done
);

    localparam logic [3:0] MaxBits = 4'(DATA_W);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [3:0]        dbits_q, dbits_d;
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
    logic              stop2_q, stop2_d;
    logic              brk_q, brk_d;
    logic              txd_q, txd_d;
    logic              done_q, done_d;

    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;

    logic [3:0]        eff_dbits;
    logic              data_xor;
    logic              new_par_bit;
    logic              launch;

    uart_tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (tx_valid),
        .wdata   (tx_data),
        .pop     (fifo_pop),
        .rdata   (fifo_rdata),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Frame format derived from the live config and the FIFO head word;
    // only used at the moment a frame is launched.
    always_comb begin
        eff_dbits = ((cfg_dbits < 4'd5) || (cfg_dbits > MaxBits)) ? MaxBits : cfg_dbits;
        data_xor  = 1'b0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (4'(i) < eff_dbits) data_xor = data_xor ^ fifo_rdata[i];
        end
        case (cfg_parity)
            ParEven:  new_par_bit = data_xor;
            ParOdd:   new_par_bit = ~data_xor;
            ParMark:  new_par_bit = 1'b1;
            default:  new_par_bit = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        dbits_d   = dbits_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;
        brk_d     = brk_q;
        txd_d     = txd_q;
        done_d    = 1'b0;
        fifo_pop  = 1'b0;
        launch    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (baud_tick) launch = 1'b1;
            end
            StStart: begin
                if (baud_tick) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                    txd_d     = shift_q[0];
                    shift_d   = shift_q >> 1;
                end
            end
            StData: begin
                if (baud_tick) begin
                    if (bit_cnt_q == dbits_q - 4'd1) begin
                        state_d = par_en_q ? StParity : StStop1;
                        txd_d   = par_en_q ? par_bit_q : 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        txd_d     = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            StParity: begin
                if (baud_tick) begin
                    state_d = StStop1;
                    txd_d   = 1'b1;
                end
            end
            StStop1: begin
                // After a break the single stop period ends the sequence silently.
                if (baud_tick) begin
                    if (stop2_q && !brk_q) begin
                        state_d = StStop2;
                        txd_d   = 1'b1;
                    end else begin
                        launch = 1'b1;
                        done_d = !brk_q;
                    end
                end
            end
            StStop2: begin
                if (baud_tick) begin
                    launch = 1'b1;
                    done_d = 1'b1;
                end
            end
            StBreak: begin
                if (baud_tick && !break_req) begin
                    state_d = StStop1;
                    txd_d   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // The end of a stop period behaves like an idle tick so queued frames
        // follow with no idle bit in between.
        if (launch) begin
            state_d = StIdle;
            txd_d   = 1'b1;
            brk_d   = 1'b0;
            if (break_req) begin
                state_d = StBreak;
                txd_d   = 1'b0;
                brk_d   = 1'b1;
            end else if (!fifo_empty) begin
                fifo_pop  = 1'b1;
                state_d   = StStart;
                txd_d     = 1'b0;
                shift_d   = fifo_rdata;
                dbits_d   = eff_dbits;
                par_en_d  = parity_on(cfg_parity);
                par_bit_d = new_par_bit;
                stop2_d   = cfg_stop2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            dbits_q   <= MaxBits;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            brk_q     <= 1'b0;
            txd_q     <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            dbits_q   <= dbits_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            brk_q     <= brk_d;
            txd_q     <= txd_d;
            done_q    <= done_d;
        end
    end

    assign txd      = txd_q;
    assign busy     = (state_q != StIdle);
    assign tx_done  = done_q;
    assign tx_ready = !fifo_full;

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param (DATA_W=8, FIFO_DEPTH=4).
// Stimulus pushes expected line waveforms into a queue; a line decoder
// samples txd once per bit period and compares complete frames.
module tb_uart_tx_param;

    localparam int unsigned DW = 8;
    localparam int unsigned FD = 4;

    logic       clk        = 1'b0;
    logic       reset_n    = 1'b0;
    logic       baud_tick  = 1'b0;
    logic [7:0] tx_data    = 8'h00;
    logic       tx_valid   = 1'b0;
    logic [3:0] cfg_dbits  = 4'd8;
    logic [2:0] cfg_parity = 3'd0;
    logic       cfg_stop2  = 1'b0;
    logic       break_req  = 1'b0;
    logic       tx_ready;
    logic       txd;
    logic       busy;
    logic [2:0] fifo_level;
    logic       tx_done;

    uart_tx_param #(
        .DATA_W     (DW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .baud_tick  (baud_tick),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .cfg_dbits  (cfg_dbits),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .break_req  (break_req),
        .txd        (txd),
        .busy       (busy),
        .fifo_level (fifo_level),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bits;
        int          n;
        bit          b2b;
    } frame_t;

    frame_t exp_q[$];
    int     checks      = 0;
    int     errors      = 0;
    int     done_seen   = 0;
    int     done_exp    = 0;
    bit     tick_en     = 1'b1;
    bit     brk_mode    = 1'b0;
    int     brk_len_exp = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    // Reference frame: start, data LSB first, optional parity, stop bit(s).
    function automatic frame_t make_frame(logic [7:0] w, logic [3:0] d, logic [2:0] p,
                                          logic s2, bit b2b);
        frame_t f;
        int nb;
        int ones;
        nb     = (d >= 5 && d <= DW) ? int'(d) : DW;
        ones   = 0;
        f.bits = '1;
        f.b2b  = b2b;
        f.bits[0] = 1'b0;
        f.n    = 1;
        for (int i = 0; i < nb; i++) begin
            f.bits[f.n] = w[i];
            ones += int'(w[i]);
            f.n++;
        end
        if (p >= 1 && p <= 4) begin
            case (p)
                3'd1:    f.bits[f.n] = (ones % 2 == 1);
                3'd2:    f.bits[f.n] = (ones % 2 == 0);
                3'd3:    f.bits[f.n] = 1'b1;
                default: f.bits[f.n] = 1'b0;
            endcase
            f.n++;
        end
        f.bits[f.n] = 1'b1;
        f.n++;
        if (s2) begin
            f.bits[f.n] = 1'b1;
            f.n++;
        end
        return f;
    endfunction

    // Baud tick generator, one tick every four clocks.
    initial begin
        int c;
        c = 0;
        forever begin
            @(negedge clk);
            c++;
            baud_tick = tick_en && (c % 4 == 0);
        end
    end

    // Line decoder / scoreboard monitor.
    initial begin
        int          pos;
        int          idle_run;
        int          brk_cnt;
        bit          in_brk;
        bit          chk_high;
        frame_t      cur;
        logic [15:0] got;
        logic        b;
        pos = -1; idle_run = 0; brk_cnt = 0; in_brk = 0; chk_high = 0; got = '1;
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                pos = -1;
                in_brk = 0;
                idle_run = 0;
                exp_q.delete();
            end else if (baud_tick) begin
                #1;
                b = txd;
                if (pos < 0) begin
                    if (chk_high) begin
                        chk("line high after break", 32'(b), 32'd1);
                        chk_high = 0;
                    end
                    if (in_brk) begin
                        if (b == 1'b0) brk_cnt++;
                        else begin
                            chk("break length", brk_cnt, brk_len_exp);
                            in_brk = 0;
                            chk_high = 1;
                        end
                    end else if (b == 1'b0) begin
                        if (exp_q.size() > 0) begin
                            cur = exp_q.pop_front();
                            got = '1;
                            got[0] = 1'b0;
                            pos = 1;
                            if (cur.b2b) chk("idle bits between frames", idle_run, 0);
                        end else if (brk_mode) begin
                            in_brk = 1;
                            brk_cnt = 1;
                            brk_mode = 0;
                        end else begin
                            chk("start with empty scoreboard", exp_q.size(), 1);
                        end
                    end else begin
                        idle_run++;
                    end
                end else begin
                    got[pos] = b;
                    pos++;
                    if (pos == cur.n) begin
                        chk("frame bits", 32'(got), 32'(cur.bits));
                        pos = -1;
                        idle_run = 0;
                    end
                end
            end
        end
    end

    // tx_done must be single-cycle pulses.
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_done) begin
                done_seen++;
                chk("tx_done width", 32'(prev), 32'd0);
            end
            prev = tx_done;
        end
    end

    task automatic wait_level0();
        int t;
        t = 0;
        while (fifo_level != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("fifo drained", 32'(fifo_level), 32'd0);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((busy || fifo_level != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("idle and empty", 32'({busy, fifo_level}), 32'd0);
    endtask

    // Called at a negedge; returns at a negedge with the word accepted.
    task automatic push_word(input logic [7:0] w);
        int t;
        t = 0;
        tx_valid = 1'b1;
        tx_data  = w;
        while (!tx_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("push ready", 32'(tx_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic batch(input logic [3:0] d, input logic [2:0] p, input logic s2,
                         input int k, input logic [31:0] wv);
        @(negedge clk);
        cfg_dbits  = d;
        cfg_parity = p;
        cfg_stop2  = s2;
        for (int i = 0; i < k; i++) begin
            exp_q.push_back(make_frame(wv[i*8 +: 8], d, p, s2, 1'b0));
            done_exp++;
            push_word(wv[i*8 +: 8]);
        end
        wait_level0();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          c;
        int          t;
        int          mcnt;
        logic [31:0] wv;
        frame_t      f;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("reset txd", 32'(txd), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset tx_ready", 32'(tx_ready), 32'd1);
        chk("reset level", 32'(fifo_level), 32'd0);
        chk("reset tx_done", 32'(tx_done), 32'd0);
        reset_n = 1'b1;

        // Directed frames: 8N1 0x55, 7E2 0x41, 7O2 0x41, oversized dbits.
        batch(4'd8, 3'd0, 1'b0, 1, 32'h55);
        batch(4'd7, 3'd1, 1'b1, 1, 32'h41);
        batch(4'd7, 3'd2, 1'b1, 1, 32'h41);
        batch(4'd12, 3'd0, 1'b0, 2, 32'h3CA7);
        wait_drain();

        // Random formats; config changes right after the last pop of a batch.
        for (int n = 0; n < 24; n++) begin
            wv = $urandom;
            batch(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), int'($urandom_range(1, 4)), wv);
        end
        wait_drain();

        // Overflow: ticks paused with a frame in flight, six writes offered.
        batch(4'd8, 3'd0, 1'b0, 1, 32'h96);
        @(negedge clk);
        tick_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mcnt = 0;
        for (int i = 0; i < 6; i++) begin
            wv       = $urandom;
            tx_valid = 1'b1;
            tx_data  = wv[7:0];
            if (mcnt < int'(FD)) begin
                exp_q.push_back(make_frame(wv[7:0], 4'd8, 3'd0, 1'b0, 1'b1));
                done_exp++;
                mcnt++;
            end
            @(negedge clk);
        end
        tx_valid = 1'b0;
        chk("tx_ready when full", 32'(tx_ready), 32'd0);
        chk("level when full", 32'(fifo_level), 32'(FD));
        tick_en = 1'b1;
        wait_drain();

        // Break requested mid-frame: frame completes, then 20 low periods.
        brk_len_exp = 20;
        brk_mode    = 1'b1;
        wv = $urandom;
        batch(4'd8, 3'd1, 1'b0, 1, wv);
        break_req = 1'b1;
        t = 0;
        while (!tx_done && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("frame done before break", 32'(tx_done), 32'd1);
        c = 0;
        while (c < 19) begin
            @(posedge clk);
            if (baud_tick) c++;
        end
        #1;
        break_req = 1'b0;
        wait_drain();
        repeat (8) @(negedge clk);
        chk("no tx_done for break", done_seen, done_exp);

        // Reset during data bit 3 with two words still queued.
        @(negedge clk);
        cfg_dbits  = 4'd8;
        cfg_parity = 3'd0;
        cfg_stop2  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wv = $urandom;
            f  = make_frame(wv[7:0], 4'd8, 3'd0, 1'b0, 1'b0);
            exp_q.push_back(f);
            push_word(wv[7:0]);
        end
        t = 0;
        while (txd && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("start bit seen", 32'(txd), 32'd0);
        c = 0;
        while (c < 4) begin
            @(posedge clk);
            if (baud_tick) c++;
        end
        @(negedge clk);
        chk("level before reset", 32'(fifo_level), 32'd2);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid-frame reset txd", 32'(txd), 32'd1);
        chk("mid-frame reset busy", 32'(busy), 32'd0);
        chk("mid-frame reset level", 32'(fifo_level), 32'd0);
        chk("mid-frame reset tx_ready", 32'(tx_ready), 32'd1);
        chk("mid-frame reset tx_done", 32'(tx_done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // One more frame after reset to show recovery.
        batch(4'd5, 3'd3, 1'b1, 1, 32'h1B);
        wait_drain();
        repeat (20) @(negedge clk);
        chk("scoreboard empty", exp_q.size(), 0);
        chk("tx_done count", done_seen, done_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
